cnn_row_feeder: RTL and testbench
=================================

CNN_ROW_FEEDER -- requirements
Module: cnn_row_feeder

Interface
REQ-001 Parameters (name, default, meaning): IMG_W, 28, pixels per row; IMG_H, 28, rows per image; PRIME_ROWS, 4, rows sent before the first interrupt; OUT_BEATS, 196, expected output beats per image.
REQ-002 The block SHALL have exactly one clock and an asynchronous, active-high reset; the ports are listed below.
REQ-003 axi_clk  in  1  clock; all state SHALL update on its rising edge.
REQ-004 axi_rst  in  1  asynchronous, active-high reset.
REQ-005 i_start  in  1  single-cycle request to stream one image.
REQ-006 o_mem_rd_en  out  1  frame-memory read strobe.
REQ-007 o_mem_addr  out  10  frame-memory pixel address.
REQ-008 i_mem_data  in  8  pixel data; valid 1 cycle after the read strobe.
REQ-009 o_data_valid  out  1  pixel strobe to the CNN.
REQ-010 o_data  out  8  pixel to the CNN.
REQ-011 i_intr  in  1  CNN line-buffer-free interrupt, level signal.
REQ-012 i_out_valid  in  16  CNN output-valid lanes.
REQ-013 o_busy  out  1  high from start acceptance until the done pulse.
REQ-014 o_done  out  1  single-cycle end-of-image pulse.
REQ-015 o_row_idx  out  5  index of the last row fully issued.

Function
REQ-016 States: IDLE, PRIME, GAP, WAIT_INTR, ROW, DRAIN, DONE.
REQ-017 IDLE: an i_start high at edge T SHALL move the block to PRIME; o_mem_rd_en SHALL be high from T+1; o_data_valid SHALL be high from T+2.
REQ-018 PRIME: the block SHALL issue PRIME_ROWS*IMG_W (112) reads on consecutive cycles, then enter GAP.
REQ-019 ROW: the block SHALL issue IMG_W reads on consecutive cycles, then enter GAP.
REQ-020 GAP SHALL last exactly one cycle with o_mem_rd_en low; from GAP the block SHALL go to DRAIN if all IMG_H rows are issued, otherwise to WAIT_INTR.
REQ-021 o_data_valid/o_data SHALL be o_mem_rd_en/i_mem_data delayed one cycle, so each row appears as a gap-free burst followed by at least one invalid cycle.
REQ-022 Address SHALL be row*IMG_W+col, with row 0..IMG_H-1 and col 0..IMG_W-1.
REQ-023 Each rising edge of i_intr (registered edge detect) SHALL increment a pending counter, saturating at 3; this SHALL be counted in PRIME, GAP, WAIT_INTR and ROW, and ignored in IDLE, DRAIN and DONE.
REQ-024 WAIT_INTR: when pending>0, the block SHALL decrement pending and enter ROW on the next cycle.
REQ-025 If an intr edge and a decrement occur in the same cycle, pending SHALL be left unchanged.
REQ-026 DRAIN: the block SHALL count the cycles with |i_out_valid, including cycles before DRAIN within the same image; on reaching OUT_BEATS it SHALL enter DONE.
REQ-027 Beats counted beyond OUT_BEATS SHALL be ignored.
REQ-028 DONE: o_done SHALL be high for one cycle, o_busy SHALL drop on the same edge, and the block SHALL then return to IDLE.
REQ-029 i_start outside IDLE SHALL be ignored.
REQ-030 o_row_idx SHALL update when a row's last read issues; during PRIME it SHALL step 0..3.

Reset
REQ-031 While axi_rst is high, the block SHALL enter IDLE, and every output SHALL be 0: o_mem_rd_en=0, o_mem_addr=0, o_data_valid=0, o_data=0, o_busy=0, o_done=0, o_row_idx=0.
REQ-032 While axi_rst is high, pending and the beat counter SHALL be 0.
REQ-033 Reset asserted mid-image SHALL abort at once with no o_done pulse.
REQ-034 The first i_start after reset deassertion SHALL be honoured.

Configuration
REQ-035 Macro ROW_FLIP_EN: when defined, the row term of the address SHALL be (IMG_H-1-row), giving a bottom-up bitmap to top-down raster conversion.
REQ-036 When ROW_FLIP_EN is undefined, the address SHALL be row*IMG_W+col; all timing SHALL be identical in both builds.

Verification
REQ-037 Start pulse, memory loaded with addr[7:0] -> 112 contiguous beats 0x00..0x6F, then valid low, then a stall until the first intr.
REQ-038 Intr pulse after the prime rows -> beats 112..139 start 2 cycles after the edge; o_row_idx=4.
REQ-039 Three intr pulses during PRIME -> rows 4..6 stream with only 1-cycle gaps; a fourth early pulse is lost to saturation.
REQ-040 All rows streamed, then 196 cycles of i_out_valid=16'h0001 -> one o_done pulse; o_busy=0 on the next cycle; extra beats cause no second pulse.
REQ-041 ROW_FLIP_EN build -> first address 756, first row ends at 783; the last row spans 0..27.
REQ-042 axi_rst pulse during row 10 -> all outputs 0 immediately, no o_done; a fresh i_start restarts at address 0 (756 when flipped).

Source files
------------

// File: rtl/cnn_row_feeder.sv
// Streams a frame-memory image row by row into a CNN, paced by line-buffer interrupts.
// Optional `ROW_FLIP_EN: reads rows bottom-up (bitmap to raster conversion).
module cnn_row_feeder #(
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int PRIME_ROWS = 4,
   parameter int OUT_BEATS  = 196
) (
   input  logic        axi_clk,
   input  logic        axi_rst,
   input  logic        i_start,
   output logic        o_mem_rd_en,
   output logic [9:0]  o_mem_addr,
   input  logic [7:0]  i_mem_data,
   output logic        o_data_valid,
   output logic [7:0]  o_data,
   input  logic        i_intr,
   input  logic [15:0] i_out_valid,
   output logic        o_busy,
   output logic        o_done,
   output logic [4:0]  o_row_idx
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H + 1);
   localparam int BW = $clog2(OUT_BEATS + 1);

   typedef enum logic [2:0] {
      IDLE, PRIME, GAP, WAIT_INTR, ROW, DRAIN, DONE
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [1:0] pend_q, pend_d;
   logic [BW-1:0] beat_q, beat_d;
   logic intr_q, intr_d;
   logic rd_q, rd_d;
   logic [9:0] addr_q, addr_d;
   logic dv_q, dv_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic [4:0] ridx_q, ridx_d;

   logic last_col, take, issue;
   logic intr_edge, count_intr;
   logic [RW-1:0] row_term;

   always_comb begin
      last_col = (col_q == CW'(IMG_W - 1));
      take = (state_q == WAIT_INTR) && (pend_q != 2'd0);
      // the first read of a row leaves from WAIT_INTR so rows are 1 cycle apart
      issue = (state_q == PRIME) || (state_q == ROW) || take;
      intr_edge = i_intr & ~intr_q;
      count_intr = (state_q == PRIME) || (state_q == GAP) ||
                   (state_q == WAIT_INTR) || (state_q == ROW);
`ifdef ROW_FLIP_EN
      row_term = RW'(IMG_H - 1) - row_q;
`else
      row_term = row_q;
`endif

      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      intr_d  = i_intr;
      rd_d    = issue;
      addr_d  = addr_q;
      dv_d    = rd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ridx_d  = ridx_q;

      pend_d = pend_q;
      if (count_intr && intr_edge && !take)
         pend_d = (pend_q == 2'd3) ? 2'd3 : pend_q + 2'd1;
      else if (take && !(count_intr && intr_edge))
         pend_d = pend_q - 2'd1;

      beat_d = beat_q;
      if (state_q != IDLE && state_q != DONE && (|i_out_valid) &&
          beat_q != BW'(OUT_BEATS))
         beat_d = beat_q + 1'b1;

      if (issue) begin
         addr_d = 10'(int'(row_term) * IMG_W + int'(col_q));
         col_d = last_col ? '0 : col_q + 1'b1;
         if (last_col) begin
            row_d  = row_q + 1'b1;
            ridx_d = 5'(row_q);
         end
      end

      unique case (state_q)
         IDLE: begin
            pend_d = 2'd0;
            beat_d = '0;
            if (i_start) begin
               state_d = PRIME;
               busy_d  = 1'b1;
               col_d   = '0;
               row_d   = '0;
               ridx_d  = '0;
            end
         end
         PRIME:
            if (last_col && row_q == RW'(PRIME_ROWS - 1))
               state_d = GAP;
         GAP:
            state_d = (row_q == RW'(IMG_H)) ? DRAIN : WAIT_INTR;
         WAIT_INTR:
            if (take) state_d = ROW;
         ROW:
            if (last_col) state_d = GAP;
         DRAIN:
            if (beat_d == BW'(OUT_BEATS)) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         DONE:
            state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         pend_q  <= '0;
         beat_q  <= '0;
         intr_q  <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ridx_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         pend_q  <= pend_d;
         beat_q  <= beat_d;
         intr_q  <= intr_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         dv_q    <= dv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ridx_q  <= ridx_d;
      end
   end

   assign o_mem_rd_en  = rd_q;
   assign o_mem_addr   = addr_q;
   assign o_data_valid = dv_q;
   // memory output is already one cycle behind the strobe; gate it to the strobe
   assign o_data       = dv_q ? i_mem_data : 8'd0;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_row_idx    = ridx_q;

endmodule

// File: tb/tb_cnn_row_feeder.sv
// Bench for cnn_row_feeder: table of prime-time interrupt cases, directed
// latency/drain/reset sequences and randomized images against a raster model.
module tb_cnn_row_feeder;
   localparam int W = 28;
   localparam int H = 28;
   localparam int NPIX = W * H;

   logic clk = 0;
   logic rst = 1;
   logic start = 0;
   logic intr = 0;
   logic [15:0] ov = '0;
   logic [7:0] mem_data = '0;
   logic rd_en, dv, busy, done;
   logic [9:0] addr;
   logic [7:0] data;
   logic [4:0] ridx;

   int total = 0;
   int bad = 0;
   logic [7:0] mem [0:1023];

   always #5 clk = ~clk;

   cnn_row_feeder dut (
      .axi_clk(clk), .axi_rst(rst), .i_start(start),
      .o_mem_rd_en(rd_en), .o_mem_addr(addr), .i_mem_data(mem_data),
      .o_data_valid(dv), .o_data(data), .i_intr(intr),
      .i_out_valid(ov), .o_busy(busy), .o_done(done), .o_row_idx(ridx)
   );

   // synchronous-read frame memory
   always @(posedge clk) if (rd_en) mem_data <= mem[addr];

   function automatic int exp_addr(int k);
      int r;
      r = k / W;
`ifdef ROW_FLIP_EN
      r = H - 1 - r;
`endif
      return r * W + k % W;
   endfunction

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // stream monitor: raster-order model of addresses and pixels
   int beat_k = 0, rd_k = 0, run = 0, gap = 0;
   bit prev_v = 0;
   int bursts[$];
   int gaps[$];

   always @(negedge clk) begin
      if (rst || (start && !busy)) begin
         beat_k = 0; rd_k = 0; run = 0; gap = 0; prev_v = 0;
         bursts.delete(); gaps.delete();
      end else begin
         if (rd_en) begin
            check("rd_addr", int'(addr), exp_addr(rd_k));
            rd_k++;
         end
         if (dv) begin
            check("pixel", int'(data), int'(mem[exp_addr(beat_k)]));
            if (!prev_v && beat_k > 0) gaps.push_back(gap);
            beat_k++; run++; gap = 0;
         end else begin
            if (prev_v) begin
               bursts.push_back(run);
               run = 0;
            end
            gap++;
         end
         prev_v = dv;
      end
   end

   int done_cnt = 0, ov_cnt = 0, ov_at_done = 0;
   bit rand_ov = 0;

   task automatic tick;
      @(posedge clk); #1;
      if (done) begin
         done_cnt++;
         ov_at_done = ov_cnt;
      end
      if (rand_ov) begin
         ov = ($urandom_range(0, 2) == 0) ?
              (16'd1 << $urandom_range(0, 15)) : 16'd0;
         if (ov != 0) ov_cnt++;
      end
   endtask

   task automatic pulse(int w);
      intr = 1;
      repeat (w) tick;
      intr = 0;
      tick;
   endtask

   task automatic load_mem(bit rnd);
      for (int a = 0; a < 1024; a++)
         mem[a] = rnd ? 8'($urandom) : 8'(a);
   endtask

   task automatic start_image(bit rnd_mem, bit rnd_ov);
      load_mem(rnd_mem);
      done_cnt = 0; ov_cnt = 0;
      start = 1;
      tick;
      start = 0;
      check("start_rd_low", int'(rd_en), 0);
      check("busy_on", int'(busy), 1);
      tick;
      check("first_rd", int'(rd_en), 1);
      check("first_addr", int'(addr), exp_addr(0));
      tick;
      check("first_valid", int'(dv), 1);
      rand_ov = rnd_ov;
   endtask

   task automatic wait_stall;
      int idle = 0, g = 0;
      while ((beat_k == 0 || idle < 20) && g < 600) begin
         tick; g++;
         idle = dv ? 0 : idle + 1;
      end
      check("stall_timeout", int'(g < 600), 1);
   endtask

   task automatic feed_rows(bit rnd);
      int g = 0;
      while (beat_k < NPIX && g < 300) begin
         pulse(rnd ? $urandom_range(1, 3) : 1);
         repeat (rnd ? $urandom_range(0, 40) : 35) tick;
         g++;
      end
      repeat (4) tick;
      check("all_pixels", beat_k, NPIX);
      check("last_row_idx", int'(ridx), H - 1);
      check("burst_count", bursts.size(), 1 + H - 4);
      foreach (bursts[i])
         check("burst_len", bursts[i], (i == 0) ? 4 * W : W);
   endtask

   task automatic drain_exact;
      repeat (3) tick;
      ov = 16'h0001;
      for (int i = 1; i <= 196; i++) begin
         tick;
         if (i == 195) check("done_early", int'(done), 0);
         if (i == 196) begin
            check("done_pulse", int'(done), 1);
            check("busy_drop", int'(busy), 0);
         end
      end
      repeat (10) tick;
      check("busy_after", int'(busy), 0);
      check("done_count", done_cnt, 1);
      ov = '0;
   endtask

   typedef struct {
      int early;
      int exp_bursts;
      int exp_ridx;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int n, g;
      tbl[0] = '{0, 1, 3};
      tbl[1] = '{1, 2, 4};
      tbl[2] = '{2, 3, 5};
      tbl[3] = '{3, 4, 6};
      tbl[4] = '{4, 4, 6};

      load_mem(0);
      repeat (3) tick;
      check("rst_rd", int'(rd_en), 0);
      check("rst_addr", int'(addr), 0);
      check("rst_valid", int'(dv), 0);
      check("rst_data", int'(data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ridx", int'(ridx), 0);
      rst = 0;
      tick;

      foreach (tbl[t]) begin
         start_image(0, 0);
         repeat (tbl[t].early) pulse(1);
         wait_stall;
         check("bursts_pre_stall", bursts.size(), tbl[t].exp_bursts);
         check("stall_row_idx", int'(ridx), tbl[t].exp_ridx);
         foreach (gaps[i]) check("row_gap", gaps[i], 1);
         if (tbl[t].early == 0) begin
            // first valid beat expected 2 edges after the edge sampling intr
            intr = 1;
            n = 0;
            do begin
               tick; n++;
               intr = 0;
            end while (!dv && n < 10);
            check("intr_latency", n, 3);
            repeat (35) tick;
            check("row4_idx", int'(ridx), 4);
         end
         feed_rows(0);
         drain_exact;
      end

      for (int r = 0; r < 3; r++) begin
         start_image(1, 1);
         repeat (20) tick;
         start = 1;
         tick;
         start = 0;
         feed_rows(1);
         g = 0;
         while (done_cnt == 0 && g < 3000) begin
            tick; g++;
         end
         check("rand_done_seen", done_cnt, 1);
         check("done_after_beats", int'(ov_at_done >= 196), 1);
         check("rand_busy_idle", int'(busy), 0);
         repeat (20) tick;
         check("rand_single_done", done_cnt, 1);
         rand_ov = 0;
         ov = '0;
         tick;
      end

      start_image(0, 0);
      g = 0;
      while (beat_k < 10 * W && g < 40) begin
         pulse(1);
         repeat (35) tick;
         g++;
      end
      pulse(1);
      g = 0;
      while (beat_k < 10 * W + 8 && g < 40) begin
         tick; g++;
      end
      #2 rst = 1;
      #1;
      check("abort_outputs",
            int'({rd_en, addr, dv, data, busy, done, ridx}), 0);
      repeat (3) tick;
      check("abort_hold",
            int'({rd_en, addr, dv, data, busy, done, ridx}), 0);
      check("abort_no_done", done_cnt, 0);
      rst = 0;
      tick;
      start_image(0, 0);
      repeat (40) tick;
      check("restart_prime", int'(busy), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
